// File: rtl/sseg_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sseg_disp_ctrl
// Purpose  : Register-mapped controller for up to eight seven-segment digits.
//            Each digit is hex-decoded or driven from raw segment bits, with
//            a decimal point, per-digit blink and blank controls, a global
//            enable and optional leading-zero suppression.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_DIGITS : number of digits driven (1..8)
//   BLINK_DIV  : clk cycles per blink half-period (>= 2)
//   ACTIVE_LOW : 1 = segment lit when driven 0, 0 = lit when driven 1
// Ports
//   clk      in   sole clock, rising edge
//   reset    in   asynchronous, active-high reset
//   wr_en    in   write strobe (one register write per cycle)
//   rd_en    in   read strobe
//   addr     in   [3:0]  0..NUM_DIGITS-1 = digit regs, 8 = control reg
//   wr_data  in   [15:0] write data
//   rd_data  out  [15:0] registered read data, held between reads
//   rd_valid out  one-cycle pulse the edge after an accepted rd_en
//   hex      out  [8*NUM_DIGITS-1:0] digit i at [8i+7:8i], bit7 = dp,
//                 bits 6:0 = segments g..a (registered)
// Digit register : [6:0] raw segs, [11:8] nibble, [12] raw_mode, [13] dp,
//                  [14] blink_en, [15] blank, bit 7 reads 0
// Control reg    : [0] enable, [1] lz_suppress, [2] blink_sync (write-only)
// ============================================================================
module sseg_disp_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [3:0]              addr,
  input  logic [15:0]             wr_data,
  output logic [15:0]             rd_data,
  output logic                    rd_valid,
  output logic [8*NUM_DIGITS-1:0] hex
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                    c_cnt_w   = $clog2(BLINK_DIV);
  localparam logic [c_cnt_w-1:0]    c_cnt_max = c_cnt_w'(BLINK_DIV - 1);
  localparam logic [4:0]            c_num_dig = 5'(NUM_DIGITS);
  localparam logic [3:0]            c_ctrl_ad = 4'd8;
  // Digit register write mask: bit 7 is forced to 0 on every write.
  localparam logic [15:0]           c_dig_msk = 16'hFF7F;
  localparam logic [8*NUM_DIGITS-1:0] c_hex_off =
    (ACTIVE_LOW != 0) ? {(8*NUM_DIGITS){1'b1}} : {(8*NUM_DIGITS){1'b0}};

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [15:0]              r_digit [NUM_DIGITS];
  logic                     r_enable;
  logic                     r_lz;
  logic [c_cnt_w-1:0]       r_blink_cnt;
  logic                     r_blink_phase;
  logic [15:0]              r_rd_data;
  logic                     r_rd_valid;
  logic [8*NUM_DIGITS-1:0]  r_hex;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic w_is_digit;
  logic w_is_ctrl;
  logic w_sync;

  assign w_is_digit = ({1'b0, addr} < c_num_dig);
  assign w_is_ctrl  = (addr == c_ctrl_ad);
  assign w_sync     = wr_en & w_is_ctrl & wr_data[2];

  // --------------------------------------------------------------------------
  // Hex nibble to active-high segment pattern (g..a)
  // --------------------------------------------------------------------------
  function automatic logic [6:0] f_hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Register file writes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_digit[i] <= 16'h0000;
      end
      r_enable <= 1'b1;
      r_lz     <= 1'b0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (addr == 4'(i)) begin
          r_digit[i] <= wr_data & c_dig_msk;
        end
      end
      if (w_is_ctrl) begin
        r_enable <= wr_data[0];
        r_lz     <= wr_data[1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path: the mux samples the registers before this edge's write lands,
  // so a same-cycle read and write to one address returns the old contents.
  // --------------------------------------------------------------------------
  logic [15:0] w_rd_word;

  always_comb begin
    w_rd_word = 16'h0000;
    if (w_is_digit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (addr == 4'(i)) begin
          w_rd_word = r_digit[i];
        end
      end
    end else if (w_is_ctrl) begin
      w_rd_word = {14'h0000, r_lz, r_enable};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data  <= 16'h0000;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Blink timebase. A blink_sync write restarts the period and wins over a
  // wrap happening on the same edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_sync) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == c_cnt_max) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero detection. A digit is "zero-like" when it is hex mode with
  // nibble 0 and no dp. w_lead[i] is set when digit i and every digit above
  // it are zero-like; digit 0 is always shown.
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] w_zero_like;
  logic [NUM_DIGITS-1:0] w_lead;
  logic [NUM_DIGITS-1:0] w_suppress;
  logic                  w_run;

  always_comb begin
    w_lead = '0;
    w_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run     = w_run & w_zero_like[i];
      w_lead[i] = w_run;
    end
    w_suppress = {NUM_DIGITS{r_lz}} & w_lead & ~NUM_DIGITS'(1);
  end

  // --------------------------------------------------------------------------
  // Per-digit output formatting
  // --------------------------------------------------------------------------
  logic [8*NUM_DIGITS-1:0] w_hex_next;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [15:0] w_d;
    logic [6:0]  w_seg;
    logic        w_off;
    logic [7:0]  w_lit;

    assign w_d            = r_digit[i];
    assign w_zero_like[i] = ~w_d[12] & (w_d[11:8] == 4'h0) & ~w_d[13];
    assign w_seg          = w_d[12] ? w_d[6:0] : f_hex7(w_d[11:8]);
    // Any of these forces the whole digit (segments and dp) dark.
    assign w_off          = w_d[15] | ~r_enable | (w_d[14] & r_blink_phase)
                          | w_suppress[i];
    assign w_lit          = w_off ? 8'h00 : {w_d[13], w_seg};

    if (ACTIVE_LOW != 0) begin : g_inv
      assign w_hex_next[8*i +: 8] = ~w_lit;
    end else begin : g_pass
      assign w_hex_next[8*i +: 8] = w_lit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hex <= c_hex_off;
    end else begin
      r_hex <= w_hex_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign hex      = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_sseg_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_disp_ctrl
// Purpose  : Directed self-checking bench for sseg_disp_ctrl
//            (NUM_DIGITS=6, BLINK_DIV=4, ACTIVE_LOW=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_disp_ctrl;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [47:0] hex;

  int checks;
  int errors;

  logic [6:0] seg_tbl [16];

  localparam logic [47:0] c_all_off  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] c_all_zero = 48'hC0C0_C0C0_C0C0;

  sseg_disp_ctrl #(
    .NUM_DIGITS(6),
    .BLINK_DIV (4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .hex     (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // All stimulus changes at 1 time unit after a rising edge; outputs are
  // sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (hex !== c_all_off) begin
      errors++;
      $display("FAIL reset_hex: got %h expected %h", hex, c_all_off);
    end
    checks++;
    if (rd_data !== 16'h0000 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd: got data %h valid %b expected 0000/0", rd_data, rd_valid);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (hex !== c_all_zero) begin
      errors++;
      $display("FAIL first_edge_hex: got %h expected %h", hex, c_all_zero);
    end
    do_read(4'd8);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0001) begin
      errors++;
      $display("FAIL reset_ctrl_read: got %h valid %b expected 0001/1", rd_data, rd_valid);
    end
    do_read(4'd3);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_digit_read: got %h valid %b expected 0000/1", rd_data, rd_valid);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_hex_write();
    logic [7:0] exp;
    do_write(4'd2, 16'h0A00);
    checks++;
    if (hex[23:16] !== 8'hC0) begin
      errors++;
      $display("FAIL write_latency: got %h expected c0 one edge after write", hex[23:16]);
    end
    tick();
    checks++;
    if (hex[23:16] !== 8'h88) begin
      errors++;
      $display("FAIL digit2_A: got %h expected 88", hex[23:16]);
    end
    do_read(4'd2);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0A00) begin
      errors++;
      $display("FAIL read_digit2: got %h valid %b expected 0a00/1", rd_data, rd_valid);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0A00) begin
      errors++;
      $display("FAIL read_hold: got %h valid %b expected 0a00/0", rd_data, rd_valid);
    end
    // Raw mode with all seven segments; bit 7 of the register must read 0.
    do_write(4'd1, 16'h1FFF);
    tick();
    checks++;
    if (hex[15:8] !== 8'h80) begin
      errors++;
      $display("FAIL raw_segs: got %h expected 80", hex[15:8]);
    end
    do_read(4'd1);
    checks++;
    if (rd_data !== 16'h1F7F) begin
      errors++;
      $display("FAIL bit7_reads_zero: got %h expected 1f7f", rd_data);
    end
    // Full decode table on digit 2.
    for (int n = 0; n < 16; n++) begin
      do_write(4'd2, {4'h0, 4'(n), 8'h00});
      tick();
      exp = ~{1'b0, seg_tbl[n]};
      checks++;
      if (hex[23:16] !== exp) begin
        errors++;
        $display("FAIL decode_%0d: got %h expected %h", n, hex[23:16], exp);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_lz_suppress();
    do_write(4'd5, 16'h0000);
    do_write(4'd4, 16'h0000);
    do_write(4'd3, 16'h0100);
    do_write(4'd2, 16'h0000);
    do_write(4'd1, 16'h0000);
    do_write(4'd0, 16'h0700);
    do_write(4'd8, 16'h0007);
    do_read(4'd8);
    checks++;
    if (rd_data !== 16'h0003) begin
      errors++;
      $display("FAIL ctrl_sync_reads0: got %h expected 0003", rd_data);
    end
    checks++;
    if (hex !== 48'hFFFF_F9C0_C0F8) begin
      errors++;
      $display("FAIL lz_basic: got %h expected fffff9c0c0f8", hex);
    end
    // A dp on the top digit stops suppression.
    do_write(4'd5, 16'h2000);
    tick();
    checks++;
    if (hex !== 48'h40C0_F9C0_C0F8) begin
      errors++;
      $display("FAIL lz_dp_stop: got %h expected 40c0f9c0c0f8", hex);
    end
    // Blanked non-zero digit 3 still ends the leading-zero run.
    do_write(4'd5, 16'h0000);
    do_write(4'd3, 16'h8100);
    tick();
    checks++;
    if (hex !== 48'hFFFF_FFC0_C0F8) begin
      errors++;
      $display("FAIL lz_blank: got %h expected ffffffc0c0f8", hex);
    end
    // All zero: only digit 0 remains lit.
    do_write(4'd3, 16'h0000);
    do_write(4'd0, 16'h0000);
    tick();
    checks++;
    if (hex !== 48'hFFFF_FFFF_FFC0) begin
      errors++;
      $display("FAIL lz_all_zero: got %h expected ffffffffffc0", hex);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_blink();
    logic [7:0] exp;
    do_write(4'd0, 16'h4100);
    do_write(4'd8, 16'h0005);
    // Phase after sync edge E+m is 0 for m=0..3, 1 for m=4..7, 0 for 8..11;
    // hex lags the phase by one edge.
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = (k >= 5 && k <= 8) ? 8'hFF : 8'hF9;
      checks++;
      if (hex[7:0] !== exp) begin
        errors++;
        $display("FAIL blink_k%0d: got %h expected %h", k, hex[7:0], exp);
      end
    end
    // Re-sync, then sync again on the edge that would otherwise wrap.
    do_write(4'd8, 16'h0005);
    tick();
    tick();
    tick();
    do_write(4'd8, 16'h0005);
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 5) ? 8'hFF : 8'hF9;
      checks++;
      if (hex[7:0] !== exp) begin
        errors++;
        $display("FAIL blink_sync_k%0d: got %h expected %h", k, hex[7:0], exp);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_disable_unmapped();
    do_write(4'd4, 16'h0300);
    do_write(4'd8, 16'h0000);
    tick();
    checks++;
    if (hex !== c_all_off) begin
      errors++;
      $display("FAIL disable_hex: got %h expected %h", hex, c_all_off);
    end
    do_read(4'd9);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL read_unmapped9: got %h valid %b expected 0000/1", rd_data, rd_valid);
    end
    do_write(4'd12, 16'hFFFF);
    do_write(4'd6, 16'hFFFF);
    do_read(4'd8);
    checks++;
    if (rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL ignore_wr12_ctrl: got %h expected 0000", rd_data);
    end
    do_read(4'd4);
    checks++;
    if (rd_data !== 16'h0300) begin
      errors++;
      $display("FAIL ignore_wr12_digit4: got %h expected 0300", rd_data);
    end
    do_read(4'd6);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL read_unmapped6: got %h valid %b expected 0000/1", rd_data, rd_valid);
    end
    checks++;
    if (hex !== c_all_off) begin
      errors++;
      $display("FAIL disable_hold: got %h expected %h", hex, c_all_off);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    do_write(4'd8, 16'h0001);
    do_write(4'd0, 16'h0005);
    addr    = 4'd0;
    wr_data = 16'h2003;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0005) begin
      errors++;
      $display("FAIL rw_same_old: got %h valid %b expected 0005/1", rd_data, rd_valid);
    end
    do_read(4'd0);
    checks++;
    if (rd_data !== 16'h2003) begin
      errors++;
      $display("FAIL rw_same_new: got %h expected 2003", rd_data);
    end
    // 0x2003 leaves raw_mode clear, so raw 0x03 with dp is written as 0x3003.
    do_write(4'd0, 16'h3003);
    tick();
    checks++;
    if (hex[7:0] !== 8'h7C) begin
      errors++;
      $display("FAIL raw_dp: got %h expected 7c", hex[7:0]);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    do_write(4'd3, 16'h0800);
    do_read(4'd3);
    addr  = 4'd0;
    rd_en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (hex !== c_all_off || rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: got hex %h data %h expected all-off/0000", hex, rd_data);
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard_read: got rd_valid %b expected 0", rd_valid);
    end
    tick();
    checks++;
    if (hex !== c_all_off || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got hex %h valid %b expected all-off/0", hex, rd_valid);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (hex !== c_all_zero || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got hex %h valid %b expected %h/0", hex, rd_valid, c_all_zero);
    end
    do_read(4'd3);
    checks++;
    if (rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_clears_digit: got %h expected 0000", rd_data);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = 4'd0;
    wr_data = 16'h0000;
    seg_tbl[0]  = 7'h3F; seg_tbl[1]  = 7'h06; seg_tbl[2]  = 7'h5B; seg_tbl[3]  = 7'h4F;
    seg_tbl[4]  = 7'h66; seg_tbl[5]  = 7'h6D; seg_tbl[6]  = 7'h7D; seg_tbl[7]  = 7'h07;
    seg_tbl[8]  = 7'h7F; seg_tbl[9]  = 7'h6F; seg_tbl[10] = 7'h77; seg_tbl[11] = 7'h7C;
    seg_tbl[12] = 7'h39; seg_tbl[13] = 7'h5E; seg_tbl[14] = 7'h79; seg_tbl[15] = 7'h71;
    #1;

    test_reset();
    test_hex_write();
    test_lz_suppress();
    test_blink();
    test_disable_unmapped();
    test_back_to_back();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
